// File: rtl/irq_vector_pkg.sv
// Shared types and helpers for the interrupt vector controller.
package irq_vector_pkg;

    localparam int N_REQ = 8;
    localparam int VEC_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        QUAL = 2'd1,
        PEND = 2'd2,
        SERV = 2'd3
    } state_t;

    // One-hot clear mask for a request index.
    function automatic logic [N_REQ-1:0] onehot8(input logic [VEC_W-1:0] v);
        logic [N_REQ-1:0] one;
        one = {{(N_REQ-1){1'b0}}, 1'b1};
        return one << v;
    endfunction

endpackage

// File: rtl/irq_stable_qual.sv
// Stability qualifier: tracks the candidate encoder code and how many
// consecutive identical samples have been seen. stable flags the sample
// that completes STABLE_CYC matches.
module irq_stable_qual
    import irq_vector_pkg::*;
#(
    parameter int STABLE_CYC = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic [VEC_W-1:0] enc_y,
    input  logic             sample_en,
    output logic             stable,
    output logic [VEC_W-1:0] cand
);

    logic [7:0] cnt;
    logic       match;

    // cnt==0 means no candidate yet, so any code starts a fresh run.
    assign match  = (cnt != 8'd0) && (enc_y == cand);
    assign stable = sample_en && match && (({1'b0, cnt} + 9'd1) == 9'(STABLE_CYC));

    // Candidate register and consecutive-match counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= 8'd0;
            cand <= '0;
        end else if (clear) begin
            cnt  <= 8'd0;
        end else if (sample_en) begin
            if (match) begin
                cnt <= cnt + 8'd1;
            end else begin
                cand <= enc_y;
                cnt  <= 8'd1;
            end
        end
    end

endmodule

// File: rtl/irq_vector_ctrl.sv
// Interrupt vector controller behind an 8-to-3 priority encoder.
// Qualifies the encoder code, latches it as vec, runs irq/ack/eoi and
// pulses a one-hot clear on end-of-interrupt.
// Optional: define IRQ_TIMEOUT_EN to abandon an unacknowledged irq after
// TIMEOUT_CYC cycles in PEND and raise the sticky timeout flag.
//
//   state | meaning
//   IDLE  | encoder enabled, waiting for a consistent request
//   QUAL  | candidate code being checked for STABLE_CYC identical samples
//   PEND  | irq raised, encoder frozen, waiting for ack
//   SERV  | acknowledged, waiting for eoi
module irq_vector_ctrl
    import irq_vector_pkg::*;
#(
    parameter int STABLE_CYC  = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [VEC_W-1:0] enc_y,
    input  logic             enc_gs,
    input  logic             enc_eo,
    output logic             enc_ei,
    output logic             irq,
    output logic [VEC_W-1:0] vec,
    input  logic             ack,
    input  logic             eoi,
    output logic [N_REQ-1:0] clr_req,
    output logic             busy,
    output logic             timeout
);

    // Reject illegal parameter values at elaboration.
    if (STABLE_CYC < 2 || STABLE_CYC > 255) begin : g_bad_stable
        $error("irq_vector_ctrl: STABLE_CYC out of range");
    end
    if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_timeout
        $error("irq_vector_ctrl: TIMEOUT_CYC out of range");
    end

    state_t             state, state_n;
    logic               sample_ok, stable, tmo_fire;
    logic [VEC_W-1:0]   cand;
    logic               enc_ei_n, irq_n, busy_n, timeout_n;
    logic [VEC_W-1:0]   vec_n;
    logic [N_REQ-1:0]   clr_req_n;

    // GS with EO set is an inconsistent encoder output and never qualifies.
    assign sample_ok = ((state == IDLE) || (state == QUAL)) && enc_gs && !enc_eo;

    irq_stable_qual #(.STABLE_CYC(STABLE_CYC)) u_qual (
        .clk       (clk),
        .rst       (rst),
        .clear     (!sample_ok || stable),
        .enc_y     (enc_y),
        .sample_en (sample_ok),
        .stable    (stable),
        .cand      (cand)
    );

`ifdef IRQ_TIMEOUT_EN
    logic [15:0] tmo_cnt;

    // Cycles spent in PEND; zero on every PEND entry.
    always_ff @(posedge clk) begin
        if (rst || state != PEND) tmo_cnt <= 16'd0;
        else                      tmo_cnt <= tmo_cnt + 16'd1;
    end

    assign tmo_fire = (state == PEND) && (tmo_cnt == 16'(TIMEOUT_CYC - 1));
`else
    assign tmo_fire = 1'b0;
`endif

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            enc_ei  <= 1'b0;
            irq     <= 1'b0;
            vec     <= '0;
            clr_req <= '0;
            busy    <= 1'b0;
            timeout <= 1'b0;
        end else begin
            state   <= state_n;
            enc_ei  <= enc_ei_n;
            irq     <= irq_n;
            vec     <= vec_n;
            clr_req <= clr_req_n;
            busy    <= busy_n;
            timeout <= timeout_n;
        end
    end

    // Next-state decode; ack beats a simultaneous timeout.
    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (sample_ok) state_n = QUAL;
            QUAL: begin
                if (!sample_ok)  state_n = IDLE;
                else if (stable) state_n = PEND;
            end
            PEND: begin
                if (ack)           state_n = SERV;
                else if (tmo_fire) state_n = IDLE;
            end
            SERV: if (eoi) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Next values of the registered outputs.
    always_comb begin
        enc_ei_n  = enc_ei;
        irq_n     = irq;
        vec_n     = vec;
        busy_n    = busy;
        timeout_n = timeout;
        clr_req_n = '0;
        case (state)
            IDLE: enc_ei_n = 1'b1;
            QUAL: begin
                enc_ei_n = 1'b1;
                if (stable) begin
                    vec_n    = cand;
                    irq_n    = 1'b1;
                    busy_n   = 1'b1;
                    enc_ei_n = 1'b0;
                end
            end
            PEND: begin
                if (ack) begin
                    irq_n = 1'b0;
                end else if (tmo_fire) begin
                    irq_n     = 1'b0;
                    busy_n    = 1'b0;
                    enc_ei_n  = 1'b1;
                    timeout_n = 1'b1;
                end
            end
            SERV: begin
                if (eoi) begin
                    clr_req_n = onehot8(vec);
                    busy_n    = 1'b0;
                    enc_ei_n  = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule
